// File: rtl/cic_decimator.sv
// cic_decimator: N-stage CIC decimator, unpipelined integrator cascade on accepted
// samples, pipelined comb section driven by a decimation strobe that rides alongside the data.
module cic_decimator #(
    parameter int DATA_WIDTH        = 16,
    parameter int NUM_STAGES        = 3,
    parameter int DECIMATION_FACTOR = 4,
    parameter int DIFF_DELAY        = 1,
    parameter int OUT_WIDTH         = 16,
    localparam int ACC_WIDTH = DATA_WIDTH + NUM_STAGES * $clog2(DECIMATION_FACTOR * DIFF_DELAY)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  out_valid,
    output logic [OUT_WIDTH-1:0]  data_out
);
    localparam int N  = NUM_STAGES;
    localparam int R  = DECIMATION_FACTOR;
    localparam int M  = DIFF_DELAY;
    localparam int PW = $clog2(R);

    if (NUM_STAGES < 1 || NUM_STAGES > 6) begin : g_bad_stages
        $error("cic_decimator: NUM_STAGES must be 1..6");
    end
    if (DECIMATION_FACTOR < 2 || DECIMATION_FACTOR > 64) begin : g_bad_rate
        $error("cic_decimator: DECIMATION_FACTOR must be 2..64");
    end
    if (DIFF_DELAY < 1 || DIFF_DELAY > 2) begin : g_bad_delay
        $error("cic_decimator: DIFF_DELAY must be 1 or 2");
    end
    if (OUT_WIDTH < 1 || OUT_WIDTH > ACC_WIDTH) begin : g_bad_out
        $error("cic_decimator: OUT_WIDTH must be 1..ACC_WIDTH");
    end

    logic signed [ACC_WIDTH-1:0] integ      [N];
    logic signed [ACC_WIDTH-1:0] integ_next [N];
    logic signed [ACC_WIDTH-1:0] comb       [N];
    logic signed [ACC_WIDTH-1:0] comb_in    [N];
    logic signed [ACC_WIDTH-1:0] dly        [N][M];
    logic signed [ACC_WIDTH-1:0] acc;
    logic [PW-1:0]               phase;
    logic [N:0]                  strobe;
    logic                        last;

    assign last = phase == PW'(R - 1);

    // each updated integrator equals the new sample plus all previous-stage values
    always_comb begin
        acc = {{(ACC_WIDTH - DATA_WIDTH){data_in[DATA_WIDTH-1]}}, data_in};
        for (int k = 0; k < N; k++) begin
            acc           = acc + integ[k];
            integ_next[k] = acc;
        end
    end

    always_comb begin
        comb_in[0] = integ[N-1];
        for (int k = 1; k < N; k++) comb_in[k] = comb[k-1];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            phase  <= '0;
            strobe <= '0;
            for (int k = 0; k < N; k++) begin
                integ[k] <= '0;
                comb[k]  <= '0;
                for (int m = 0; m < M; m++) dly[k][m] <= '0;
            end
        end else begin
            strobe <= {strobe[N-1:0], in_valid && last};
            if (in_valid) begin
                phase <= last ? '0 : phase + 1'b1;
                for (int k = 0; k < N; k++) integ[k] <= integ_next[k];
            end
            for (int k = 0; k < N; k++) begin
                if (strobe[k]) begin
                    comb[k]   <= comb_in[k] - dly[k][M-1];
                    dly[k][0] <= comb_in[k];
                    for (int m = 1; m < M; m++) dly[k][m] <= dly[k][m-1];
                end
            end
        end
    end

    assign out_valid = strobe[N];
    assign data_out  = OUT_WIDTH'(comb[N-1] >>> (ACC_WIDTH - OUT_WIDTH));
endmodule
